// File: rtl/score_counter_pkg.sv
// Shared constants for the score counter and its glyph window (BCD width, glyph pitch).
// Also supplies the single-decade BCD successor helper used by every decade.
package score_counter_pkg;

    localparam int BCD_W       = 4;
    localparam int GLYPH_W     = 4;
    localparam int GLYPH_PITCH = 8;
    localparam int X_BASE_DEF  = 28;

    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    function automatic logic [BCD_W-1:0] bcd_succ(input logic [BCD_W-1:0] d);
        return (d == BCD_NINE) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/score_counter_bcd_digit.sv
// One BCD decade of the score: counts 0..9 on i_inc, clears on i_clr.
// o_carry ripples into the next decade when this one wraps 9 -> 0.
module bcd_digit
    import score_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_nine,
    output logic             o_carry
);

    logic [BCD_W-1:0] r_digit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_digit <= '0;
        end else if (i_clr) begin
            r_digit <= '0;
        end else if (i_inc) begin
            r_digit <= bcd_succ(r_digit);
        end
    end

    assign o_digit = r_digit;
    assign o_nine  = (r_digit == BCD_NINE);
    assign o_carry = i_inc & o_nine;

endmodule

// File: rtl/score_counter.sv
// Running BCD game score with frame-tick prescaler, saturation, milestone pulse and digit-window mapping.
// Optional hi-score register enabled by defining SCORE_HISCORE_EN.
module score_counter
    import score_counter_pkg::*;
#(
    parameter int CONV     = 0,
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 6,
    parameter int X_BASE   = X_BASE_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_frame_tick,
    input  logic                      i_running,
    input  logic                      i_clear,
    input  logic                      i_game_over,
    input  logic                      i_show_hi,
    input  logic [9:CONV]             i_hpos,
    output logic [BCD_W-1:0]          o_num,
    output logic [9:CONV]             o_hpos,
    output logic [BCD_W*DIGITS-1:0]   o_score,
    output logic                      o_milestone,
    output logic                      o_max,
    output logic                      o_new_hi
);

    localparam int POS_W   = 10 - CONV;
    localparam int SCORE_W = BCD_W * DIGITS;
    localparam int FIELD_W = GLYPH_PITCH * DIGITS;

    logic [5:0]         r_prescale;
    logic               r_milestone;
    logic               w_tick_ok;
    logic               w_wrap;
    logic               w_step;
    logic               w_max;
    logic [DIGITS-1:0]  w_inc;
    logic [DIGITS-1:0]  w_carry;
    logic [DIGITS-1:0]  w_nine;
    logic [SCORE_W-1:0] w_score;
    logic [SCORE_W-1:0] w_disp;
    logic               w_unused_carry;

    // A saturated score freezes the prescaler as well as the digits.
    assign w_tick_ok = i_frame_tick & i_running & ~w_max;
    assign w_wrap    = (r_prescale == 6'(TICK_DIV - 1));
    assign w_step    = w_tick_ok & w_wrap & ~i_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prescale <= '0;
        end else if (i_clear) begin
            r_prescale <= '0;
        end else if (w_tick_ok) begin
            r_prescale <= w_wrap ? 6'd0 : r_prescale + 6'd1;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        if (g == 0) begin : g_lsd
            assign w_inc[g] = w_step;
        end else begin : g_upper
            assign w_inc[g] = w_carry[g-1];
        end

        bcd_digit u_digit (
            .clk     (clk),
            .rst     (rst),
            .i_inc   (w_inc[g]),
            .i_clr   (i_clear),
            .o_digit (w_score[g*BCD_W +: BCD_W]),
            .o_nine  (w_nine[g]),
            .o_carry (w_carry[g])
        );
    end

    assign w_max          = &w_nine;
    assign w_unused_carry = w_carry[DIGITS-1];

    // A carry out of the tens decade is exactly an increment that changes the hundreds.
    if (DIGITS >= 3) begin : g_mile
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_milestone <= 1'b0;
            end else begin
                r_milestone <= w_carry[1];
            end
        end
    end else begin : g_no_mile
        assign r_milestone = 1'b0;
    end

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] r_hi;
    logic               r_new_hi;

    // Packed BCD orders the same as its binary reading, so a plain compare works.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi     <= '0;
            r_new_hi <= 1'b0;
        end else begin
            r_new_hi <= 1'b0;
            if (i_game_over && (w_score > r_hi)) begin
                r_hi     <= w_score;
                r_new_hi <= 1'b1;
            end
        end
    end

    assign w_disp   = i_show_hi ? r_hi : w_score;
    assign o_new_hi = r_new_hi;
`else
    logic w_unused_hi;
    assign w_unused_hi = i_game_over ^ i_show_hi;
    assign w_disp      = w_score;
    assign o_new_hi    = 1'b0;
`endif

    logic [POS_W-1:0] w_rel;
    logic             w_in_field;
    logic [2:0]       w_col;
    logic [BCD_W-1:0] w_num;

    assign w_rel      = i_hpos - POS_W'(X_BASE);
    assign w_in_field = (i_hpos >= POS_W'(X_BASE)) && (w_rel < POS_W'(FIELD_W));
    assign w_col      = w_rel[2:0];

    // Slot 0 is leftmost and carries the most significant decade.
    always_comb begin
        w_num = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_in_field && (w_rel[POS_W-1:3] == (POS_W-3)'(k))) begin
                w_num = w_disp[BCD_W*(DIGITS-1-k) +: BCD_W];
            end
        end
    end

    assign o_num       = w_num;
    assign o_hpos      = w_in_field ? (POS_W'(X_BASE) + POS_W'(w_col)) : '0;
    assign o_score     = w_score;
    assign o_milestone = r_milestone;
    assign o_max       = w_max;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: decimal-integer reference model checked every cycle plus directed literal checks.
// Instance 0 uses TICK_DIV=6; instance 1 uses TICK_DIV=1 to reach saturation quickly.
module tb_score_counter;

    localparam int MAXV = 9999;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick[2];
    logic       clear[2];
    logic       running;
    logic       game_over;
    logic       show_hi;
    logic [9:0] hpos;

    logic [15:0] score_w[2];
    logic [3:0]  num_w[2];
    logic [9:0]  hpos_w[2];
    logic        mile_w[2];
    logic        max_w[2];
    logic        newhi_w[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_counter u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_frame_tick (tick[0]),
        .i_running    (running),
        .i_clear      (clear[0]),
        .i_game_over  (game_over),
        .i_show_hi    (show_hi),
        .i_hpos       (hpos),
        .o_num        (num_w[0]),
        .o_hpos       (hpos_w[0]),
        .o_score      (score_w[0]),
        .o_milestone  (mile_w[0]),
        .o_max        (max_w[0]),
        .o_new_hi     (newhi_w[0])
    );

    score_counter #(.TICK_DIV(1)) u_fast (
        .clk          (clk),
        .rst          (rst),
        .i_frame_tick (tick[1]),
        .i_running    (running),
        .i_clear      (clear[1]),
        .i_game_over  (game_over),
        .i_show_hi    (show_hi),
        .i_hpos       (hpos),
        .o_num        (num_w[1]),
        .o_hpos       (hpos_w[1]),
        .o_score      (score_w[1]),
        .o_milestone  (mile_w[1]),
        .o_max        (max_w[1]),
        .o_new_hi     (newhi_w[1])
    );

    task automatic chk(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, got, exp, $time);
        end
    endtask

    // Reference model: score as a plain decimal integer, prescaler as a tick count.
    int m_pts[2];
    int m_pre[2];
    int m_hi[2];
    bit m_mile[2];
    bit m_newhi[2];

    function automatic int tick_div(input int i);
        return (i == 0) ? 6 : 1;
    endfunction

    function automatic int to_bcd(input int v);
        int r;
        int t;
        r = 0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r = r | ((t % 10) << (4 * k));
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_pts[i]   <= 0;
                m_pre[i]   <= 0;
                m_hi[i]    <= 0;
                m_mile[i]  <= 1'b0;
                m_newhi[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_mile[i]  <= 1'b0;
                m_newhi[i] <= 1'b0;
`ifdef SCORE_HISCORE_EN
                if (game_over && (m_pts[i] > m_hi[i])) begin
                    m_hi[i]    <= m_pts[i];
                    m_newhi[i] <= 1'b1;
                end
`endif
                if (clear[i]) begin
                    m_pts[i] <= 0;
                    m_pre[i] <= 0;
                end else if (tick[i] && running && (m_pts[i] != MAXV)) begin
                    if (m_pre[i] == tick_div(i) - 1) begin
                        m_pre[i] <= 0;
                        m_pts[i] <= m_pts[i] + 1;
                        if ((m_pts[i] % 100) == 99) m_mile[i] <= 1'b1;
                    end else begin
                        m_pre[i] <= m_pre[i] + 1;
                    end
                end
            end
        end
    end

    function automatic int exp_num(input int i);
        int val;
        int idx;
        val = m_pts[i];
`ifdef SCORE_HISCORE_EN
        if (show_hi) val = m_hi[i];
`endif
        if (int'(hpos) < 28 || int'(hpos) >= 60) return 0;
        idx = (int'(hpos) - 28) / 8;
        return (val / pow10(3 - idx)) % 10;
    endfunction

    function automatic int exp_hpos();
        if (int'(hpos) < 28 || int'(hpos) >= 60) return 0;
        return 28 + (int'(hpos) - 28) % 8;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("score", i, int'(score_w[i]), to_bcd(m_pts[i]));
            chk("max", i, int'(max_w[i]), int'(m_pts[i] == MAXV));
            chk("milestone", i, int'(mile_w[i]), int'(m_mile[i]));
            chk("new_hi", i, int'(newhi_w[i]), int'(m_newhi[i]));
            chk("num", i, int'(num_w[i]), exp_num(i));
            chk("hpos_out", i, int'(hpos_w[i]), exp_hpos());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int w, input int n);
        for (int k = 0; k < n; k++) begin
            tick[w] = 1'b1;
            step();
        end
        tick[w] = 1'b0;
    endtask

    task automatic pulse_game_over();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        tick[0]   = 1'b0;
        tick[1]   = 1'b0;
        clear[0]  = 1'b0;
        clear[1]  = 1'b0;
        running   = 1'b1;
        game_over = 1'b0;
        show_hi   = 1'b0;
        hpos      = 10'd0;
        step();
        step();
        chk("lit_reset_score", 0, int'(score_w[0]), 0);
        chk("lit_reset_max", 0, int'(max_w[0]), 0);
        chk("lit_reset_mile", 0, int'(mile_w[0]), 0);
        rst = 1'b1;
        step();

        // 12 ticks at TICK_DIV=6 give two points; pause keeps prescaler phase.
        ticks(0, 12);
        chk("lit_12ticks", 0, int'(score_w[0]), 16'h0002);
        ticks(0, 3);
        running = 1'b0;
        ticks(0, 5);
        chk("lit_paused", 0, int'(score_w[0]), 16'h0002);
        running = 1'b1;
        ticks(0, 2);
        chk("lit_resume_phase", 0, int'(score_w[0]), 16'h0002);
        ticks(0, 1);
        chk("lit_resume_inc", 0, int'(score_w[0]), 16'h0003);

        // Reach 0x0099 with prescaler at 5, then clear on the wrapping tick.
        ticks(0, 581);
        chk("lit_pre_clear", 0, int'(score_w[0]), 16'h0099);
        tick[0]  = 1'b1;
        clear[0] = 1'b1;
        step();
        tick[0]  = 1'b0;
        clear[0] = 1'b0;
        chk("lit_clear_score", 0, int'(score_w[0]), 0);
        chk("lit_clear_mile", 0, int'(mile_w[0]), 0);
        ticks(0, 5);
        chk("lit_clear_pre", 0, int'(score_w[0]), 0);
        ticks(0, 1);
        chk("lit_clear_resume", 0, int'(score_w[0]), 16'h0001);

        // Async reset mid-count takes effect without a clock edge.
        ticks(0, 735);
        chk("lit_0123", 0, int'(score_w[0]), 16'h0123);
        rst = 1'b0;
        #1;
        chk("lit_async_score", 0, int'(score_w[0]), 0);
        chk("lit_async_num", 0, int'(num_w[0]), 0);
        step();
        rst = 1'b1;
        step();
        ticks(0, 5);
        chk("lit_reset_pre", 0, int'(score_w[0]), 0);
        ticks(0, 1);
        chk("lit_reset_pre_inc", 0, int'(score_w[0]), 16'h0001);

        // Milestone and saturation on the fast instance.
        ticks(1, 99);
        chk("lit_fast_99", 1, int'(score_w[1]), 16'h0099);
        ticks(1, 1);
        chk("lit_fast_100", 1, int'(score_w[1]), 16'h0100);
        chk("lit_mile_hi", 1, int'(mile_w[1]), 1);
        step();
        chk("lit_mile_lo", 1, int'(mile_w[1]), 0);
        ticks(1, 9899);
        chk("lit_sat", 1, int'(score_w[1]), 16'h9999);
        chk("lit_sat_max", 1, int'(max_w[1]), 1);
        ticks(1, 5);
        chk("lit_sat_hold", 1, int'(score_w[1]), 16'h9999);

        // Digit window sweep at 0x0417.
        ticks(0, 2496);
        chk("lit_0417", 0, int'(score_w[0]), 16'h0417);
        for (int h = 20; h <= 70; h++) begin
            hpos = 10'(h);
            #1;
            if (h < 28 || h >= 60) begin
                chk("lit_out_num", h, int'(num_w[0]), 0);
                chk("lit_out_hpos", h, int'(hpos_w[0]), 0);
            end else if (h <= 31) begin
                chk("lit_d3", h, int'(num_w[0]), 0);
                chk("lit_d3_hpos", h, int'(hpos_w[0]), h);
            end else if (h >= 36 && h <= 39) begin
                chk("lit_d2", h, int'(num_w[0]), 4);
                chk("lit_d2_hpos", h, int'(hpos_w[0]), h - 8);
            end else if (h >= 44 && h <= 47) begin
                chk("lit_d1", h, int'(num_w[0]), 1);
                chk("lit_d1_hpos", h, int'(hpos_w[0]), h - 16);
            end else if (h >= 52 && h <= 55) begin
                chk("lit_d0", h, int'(num_w[0]), 7);
                chk("lit_d0_hpos", h, int'(hpos_w[0]), h - 24);
            end
            step();
        end

        // Hi-score: 0x0200 then 0x0250 replace it; 0x0100 does not.
        clear[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        ticks(0, 1200);
        pulse_game_over();
`ifdef SCORE_HISCORE_EN
        chk("lit_hi_200_pulse", 0, int'(newhi_w[0]), 1);
`else
        chk("lit_hi_200_pulse", 0, int'(newhi_w[0]), 0);
`endif
        step();
        chk("lit_hi_pulse_end", 0, int'(newhi_w[0]), 0);
        ticks(0, 300);
        chk("lit_0250", 0, int'(score_w[0]), 16'h0250);
        pulse_game_over();
`ifdef SCORE_HISCORE_EN
        chk("lit_hi_250_pulse", 0, int'(newhi_w[0]), 1);
`else
        chk("lit_hi_250_pulse", 0, int'(newhi_w[0]), 0);
`endif
        clear[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        ticks(0, 600);
        chk("lit_0100", 0, int'(score_w[0]), 16'h0100);
        pulse_game_over();
        chk("lit_hi_100_nopulse", 0, int'(newhi_w[0]), 0);
        hpos    = 10'd36;
        show_hi = 1'b1;
        #1;
`ifdef SCORE_HISCORE_EN
        chk("lit_show_hi", 0, int'(num_w[0]), 2);
`else
        chk("lit_show_hi", 0, int'(num_w[0]), 1);
`endif
        hpos = 10'd44;
        #1;
`ifdef SCORE_HISCORE_EN
        chk("lit_show_hi_tens", 0, int'(num_w[0]), 5);
`else
        chk("lit_show_hi_tens", 0, int'(num_w[0]), 0);
`endif
        step();
        show_hi = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
